// File: rtl/traffic_pkg.sv
// Shared constants for the intersection controller: channel map, 10 kHz clock
// and default request-conditioner timing.
package traffic_pkg;

    localparam int CH_SENS_TH = 0;
    localparam int CH_SENS_NN = 1;
    localparam int CH_SENS_NS = 2;
    localparam int CH_BTN_NN  = 3;
    localparam int CH_BTN_NS  = 4;
    localparam int CH_BTN_TH  = 5;

    localparam int CLK_HZ = 10000;

    localparam int NUM_CH_DEF         = CH_BTN_TH + 1;
    localparam int DEBOUNCE_TICKS_DEF = 200;
    localparam int WAIT_W_DEF         = 17;
    localparam int MAX_WAIT_DEF       = 60000;
    // Quarter-second half period gives a 2 Hz lamp blink.
    localparam int BLINK_TICKS_DEF    = CLK_HZ / 4;

endpackage

// File: rtl/request_conditioner_debounce_cell.sv
// One input bit: 2-flop synchroniser followed by a debounce counter that accepts
// a new level only after it has differed from the stable level for DEBOUNCE_TICKS cycles.
module debounce_cell
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_lvl
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_lvl;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any return to the stable level restarts the qualification window.
            if (r_sync2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_lvl <= ~r_lvl;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_lvl = r_lvl;

endmodule

// File: rtl/request_conditioner.sv
// Request conditioner: per-channel debounce, request latch with ms wait aging and
// urgency flag, and pushbutton wait lamps. Define REQ_BLINK_EN to blink waiting lamps.
module request_conditioner
    import traffic_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_DEF,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int WAIT_W         = WAIT_W_DEF,
    parameter int MAX_WAIT       = MAX_WAIT_DEF,
    parameter int BLINK_TICKS    = BLINK_TICKS_DEF
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        raw_in,
    input  logic                     tick_ms,
    input  logic [NUM_CH-1:0]        serve,
    output logic [NUM_CH-1:0]        lvl,
    output logic [NUM_CH-1:0]        req,
    output logic [NUM_CH-1:0]        urgent,
    output logic [NUM_CH*WAIT_W-1:0] wait_ms,
    output logic [NUM_CH-1:0]        lamp_wait
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

    logic [NUM_CH-1:0] w_lvl;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] r_lvl_d;
    logic [NUM_CH-1:0] r_req;
    logic [NUM_CH-1:0] r_urgent;
    logic [WAIT_W-1:0] r_wait [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_cell #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_debounce (
            .i_clk   (CLK),
            .i_rst_n (reset),
            .i_raw   (raw_in[g]),
            .o_lvl   (w_lvl[g])
        );

        assign wait_ms[g*WAIT_W +: WAIT_W] = r_wait[g];
    end

    // Rises seen while disabled are dropped, not remembered for later.
    assign w_rise = w_lvl & ~r_lvl_d & {NUM_CH{en}};
    assign w_clr  = serve & r_req;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_lvl_d  <= '0;
            r_req    <= '0;
            r_urgent <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_lvl_d <= w_lvl;
            for (int i = 0; i < NUM_CH; i++) begin
                // A fresh press beats a simultaneous serve: the request restarts its wait.
                if (w_rise[i]) begin
                    r_req[i]    <= 1'b1;
                    r_wait[i]   <= '0;
                    r_urgent[i] <= 1'b0;
                end else if (w_clr[i]) begin
                    r_req[i]    <= 1'b0;
                    r_wait[i]   <= '0;
                    r_urgent[i] <= 1'b0;
                end else begin
                    r_urgent[i] <= r_req[i] && (r_wait[i] >= WAIT_LIMIT);
                    if (tick_ms && en && r_req[i] && (r_wait[i] != WAIT_SAT)) begin
                        r_wait[i] <= r_wait[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef REQ_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_TICKS + 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_phase;

    // Idle blinker parks lit so a new request shows immediately.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_req == '0) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign lamp_wait = (r_req & {NUM_CH{r_phase}}) | r_urgent;
`else
    assign lamp_wait = r_req;
`endif

    assign lvl    = w_lvl;
    assign req    = r_req;
    assign urgent = r_urgent;

endmodule
